// File: rtl/reaction_round_ctrl_pkg.sv
// rtl/reaction_round_ctrl_pkg.sv - shared types and constants for the reaction round controller
package reaction_pkg;

    typedef enum logic [2:0] {IDLE, ARM, WAIT_DELAY, STIM, DONE} state_e;

    localparam int MS_W = 14;

    localparam int DELAY_BASE_SLOW = 2000;
    localparam int DELAY_BASE_MED  = 1000;
    localparam int DELAY_BASE_FAST = 500;

    // Right-shifting Galois form of x^16+x^14+x^13+x^11+1
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic logic [MS_W-1:0] delay_ms(input logic [1:0] mode, input logic [9:0] l);
        case (mode)
            2'd0:    delay_ms = MS_W'(DELAY_BASE_SLOW) + MS_W'(l);
            2'd1:    delay_ms = MS_W'(DELAY_BASE_MED) + MS_W'(l);
            default: delay_ms = MS_W'(DELAY_BASE_FAST) + MS_W'(l[8:0]);
        endcase
    endfunction

endpackage

// File: rtl/reaction_round_ctrl_if.sv
// rtl/reaction_round_ctrl_if.sv - menu-side inputs and display-side outputs of one reaction round
interface reaction_round_ctrl_if;
    import reaction_pkg::*;

    logic            select;
    logic [1:0]      mode;
    logic            btn_react;
    logic            stim_led;
    logic            busy;
    logic [MS_W-1:0] result_ms;
    logic            result_valid;
    logic            false_start;
    logic            timeout;
    logic [MS_W-1:0] best_ms;

    modport master (
        output select, mode, btn_react,
        input  stim_led, busy, result_ms, result_valid, false_start, timeout, best_ms
    );

    modport slave (
        input  select, mode, btn_react,
        output stim_led, busy, result_ms, result_valid, false_start, timeout, best_ms
    );

endinterface

// File: rtl/reaction_round_ctrl_tick_gen.sv
// rtl/reaction_round_ctrl_tick_gen.sv - clearable prescaler producing a one-cycle measurement tick
module reaction_tick_gen #(
    parameter int DIV = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    output logic tick_o
);

    localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt_q, cnt_d;

    assign tick_o = (cnt_q == CW'(DIV - 1));

    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (clr_i || tick_o) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/reaction_round_ctrl.sv
// rtl/reaction_round_ctrl.sv - one reaction-game round: random delay, stimulus, timed response, best-time record
module reaction_round_ctrl
    import reaction_pkg::*;
#(
    parameter int          CLK_FREQ_HZ = 100_000_000,
    parameter int          TICK_HZ     = 1000,
    parameter int          MAX_MS      = 9999,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input logic                 clk,
    input logic                 rst,
    reaction_round_ctrl_if.slave bus
);

    state_e          state_q, state_d;
    logic [15:0]     lfsr_q, lfsr_d;
    logic [9:0]      lsmp_q, lsmp_d;
    logic [1:0]      mode_q, mode_d;
    logic [MS_W-1:0] delay_q, delay_d, ms_q, ms_d, result_q, result_d, best_q, best_d;
    logic            valid_q, valid_d, fs_q, fs_d, to_q, to_d;
    logic            sel_q, sel_prev_q, btn_q, btn_prev_q;
    logic            sel_rise, btn_rise, tick, tick_clr;

    assign sel_rise = sel_q & ~sel_prev_q;
    assign btn_rise = btn_q & ~btn_prev_q;
    assign lfsr_d   = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);
    assign tick_clr = (state_d != state_q) && (state_d == WAIT_DELAY || state_d == STIM);

    reaction_tick_gen #(.DIV(CLK_FREQ_HZ / TICK_HZ)) u_tick (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (tick_clr),
        .tick_o (tick)
    );

    always_comb begin
        state_d  = state_q;
        lsmp_d   = lsmp_q;
        mode_d   = mode_q;
        delay_d  = delay_q;
        ms_d     = ms_q;
        result_d = result_q;
        best_d   = best_q;
        valid_d  = valid_q;
        fs_d     = fs_q;
        to_d     = to_q;
        unique case (state_q)
            IDLE: if (sel_rise) begin
                state_d = ARM;
                mode_d  = bus.mode;
                lsmp_d  = lfsr_q[9:0];
            end
            ARM: begin
                valid_d  = 1'b0;
                fs_d     = 1'b0;
                to_d     = 1'b0;
                result_d = '0;
                if (!btn_q) begin
                    state_d = WAIT_DELAY;
                    delay_d = delay_ms(mode_q, lsmp_q);
                end
            end
            WAIT_DELAY: begin
                // A press always beats a same-cycle expiry
                if (btn_rise) begin
                    state_d  = DONE;
                    fs_d     = 1'b1;
                    result_d = '0;
                end else if (tick) begin
                    if (delay_q <= MS_W'(1)) begin
                        state_d = STIM;
                        ms_d    = '0;
                    end else begin
                        delay_d = delay_q - MS_W'(1);
                    end
                end
            end
            STIM: begin
                if (btn_rise) begin
                    state_d  = DONE;
                    result_d = ms_q;
                    valid_d  = 1'b1;
                end else if (tick && ms_q == MS_W'(MAX_MS - 1)) begin
                    state_d  = DONE;
                    result_d = MS_W'(MAX_MS);
                    to_d     = 1'b1;
                end else if (tick) begin
                    ms_d = ms_q + MS_W'(1);
                end
            end
            DONE: begin
                if (valid_q && result_q < best_q) begin
                    best_d = result_q;
                end
                if (btn_rise) begin
                    state_d = ARM;
                    mode_d  = bus.mode;
                    lsmp_d  = lfsr_q[9:0];
                end
            end
            default: state_d = IDLE;
        endcase
        if (state_q != IDLE && !bus.select) begin
            state_d = IDLE;
            valid_d = 1'b0;
            fs_d    = 1'b0;
            to_d    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            lfsr_q     <= LFSR_SEED;
            lsmp_q     <= '0;
            mode_q     <= '0;
            delay_q    <= '0;
            ms_q       <= '0;
            result_q   <= '0;
            best_q     <= MS_W'(MAX_MS);
            valid_q    <= 1'b0;
            fs_q       <= 1'b0;
            to_q       <= 1'b0;
            sel_q      <= 1'b0;
            sel_prev_q <= 1'b0;
            btn_q      <= 1'b0;
            btn_prev_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            lfsr_q     <= lfsr_d;
            lsmp_q     <= lsmp_d;
            mode_q     <= mode_d;
            delay_q    <= delay_d;
            ms_q       <= ms_d;
            result_q   <= result_d;
            best_q     <= best_d;
            valid_q    <= valid_d;
            fs_q       <= fs_d;
            to_q       <= to_d;
            sel_q      <= bus.select;
            sel_prev_q <= sel_q;
            btn_q      <= bus.btn_react;
            btn_prev_q <= btn_q;
        end
    end

    assign bus.stim_led     = (state_q == STIM);
    assign bus.busy         = (state_q == ARM) || (state_q == WAIT_DELAY) || (state_q == STIM);
    assign bus.result_ms    = result_q;
    assign bus.result_valid = valid_q;
    assign bus.false_start  = fs_q;
    assign bus.timeout      = to_q;
    assign bus.best_ms      = best_q;

endmodule

// File: tb/tb_reaction_round_ctrl.sv
// tb/tb_reaction_round_ctrl.sv - directed rounds with random delays checked against an LFSR/delay model
module tb_reaction_round_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    reaction_round_ctrl_if a ();
    reaction_round_ctrl_if b ();

    reaction_round_ctrl #(.CLK_FREQ_HZ(10_000), .TICK_HZ(1000)) dut (
        .clk (clk),
        .rst (rst),
        .bus (a.slave)
    );

    reaction_round_ctrl #(.CLK_FREQ_HZ(10_000), .TICK_HZ(1000), .MAX_MS(50)) dut_to (
        .clk (clk),
        .rst (rst),
        .bus (b.slave)
    );

    int n_chk  = 0;
    int n_fail = 0;
    int lfsr_m = 'hACE1;
    int hist[$];
    int snap[$];

    function automatic int lfsr_next(input int v);
        return (v & 1) ? ((v >> 1) ^ 'hB400) : (v >> 1);
    endfunction

    function automatic int model_delay(input int mode, input int l);
        if (mode == 0) return 2000 + (l % 1024);
        if (mode == 1) return 1000 + (l % 1024);
        return 500 + (l % 512);
    endfunction

    function automatic bit delay_matches(input int mode, input int d);
        foreach (snap[i]) if (model_delay(mode, snap[i]) == d) return 1'b1;
        return 1'b0;
    endfunction

    // Free-running reference LFSR, last few states kept to bracket the sampling cycle
    always @(posedge clk) begin
        if (rst) lfsr_m = 'hACE1;
        else     lfsr_m = lfsr_next(lfsr_m);
        hist.push_back(lfsr_m);
        if (hist.size() > 8) void'(hist.pop_front());
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_stim(input bit use_b, inout int c, output bit ok);
        ok = 1'b0;
        while (c < 40000) begin
            if ((use_b ? b.stim_led : a.stim_led) === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
            c++;
        end
    endtask

    task automatic press_after(input int ms);
        cyc(ms * 10);
        a.btn_react = 1'b1;
        cyc(3);
        a.btn_react = 1'b0;
        cyc(4);
    endtask

    task automatic restart_round(input int ms, input int exp_best);
        int  c;
        bit  ok;
        a.btn_react = 1'b1;
        cyc(3);
        a.btn_react = 1'b0;
        cyc(2);
        chk("restart_valid_cleared", a.result_valid, 0);
        chk("restart_result_cleared", a.result_ms, 0);
        chk("restart_busy", a.busy, 1);
        c = 0;
        wait_stim(1'b0, c, ok);
        chk("restart_stim_seen", ok, 1);
        press_after(ms);
        chk("round_valid", a.result_valid, 1);
        chk("round_result", a.result_ms, ms);
        chk("round_best", a.best_ms, exp_best);
    endtask

    initial begin
        int c;
        int d;
        bit ok;
        bit seen;

        a.select = 0; a.mode = 0; a.btn_react = 0;
        b.select = 0; b.mode = 0; b.btn_react = 0;
        cyc(3);
        chk("rst_stim", a.stim_led, 0);
        chk("rst_busy", a.busy, 0);
        chk("rst_result", a.result_ms, 0);
        chk("rst_valid", a.result_valid, 0);
        chk("rst_false_start", a.false_start, 0);
        chk("rst_timeout", a.timeout, 0);
        chk("rst_best", a.best_ms, 9999);
        chk("rst_best_b", b.best_ms, 50);
        rst = 1'b0;
        cyc(2);

        // Round of 37 ms in mode 2, delay checked against the model
        a.mode = 2;
        a.select = 1'b1;
        c = 0;
        repeat (4) begin @(negedge clk); c++; end
        snap = hist;
        wait_stim(1'b0, c, ok);
        chk("t1_stim_seen", ok, 1);
        d = c / 10;
        chk("t1_delay_model", delay_matches(2, d), 1);
        chk("t1_delay_range", (d >= 500 && d <= 1011), 1);
        press_after(37);
        chk("t1_valid", a.result_valid, 1);
        chk("t1_result", a.result_ms, 37);
        chk("t1_best", a.best_ms, 37);
        chk("t1_stim_off", a.stim_led, 0);
        chk("t1_busy_off", a.busy, 0);

        // Slower round keeps the record, faster one replaces it
        restart_round(52, 37);
        restart_round(20, 20);

        // False start in mode 0
        a.mode = 0;
        a.btn_react = 1'b1;
        cyc(3);
        a.btn_react = 1'b0;
        seen = 1'b0;
        repeat (50) begin @(negedge clk); seen |= a.stim_led; end
        a.btn_react = 1'b1;
        repeat (3) begin @(negedge clk); seen |= a.stim_led; end
        a.btn_react = 1'b0;
        cyc(3);
        chk("t2_false_start", a.false_start, 1);
        chk("t2_result", a.result_ms, 0);
        chk("t2_valid", a.result_valid, 0);
        chk("t2_stim_never", seen, 0);
        chk("t2_best_kept", a.best_ms, 20);

        // Button held through select edge holds ARM until release
        a.select = 1'b0;
        cyc(2);
        chk("t4_idle_busy", a.busy, 0);
        a.btn_react = 1'b1;
        a.select = 1'b1;
        cyc(4);
        snap = hist;
        cyc(300);
        chk("t4_arm_busy", a.busy, 1);
        chk("t4_arm_no_stim", a.stim_led, 0);
        a.btn_react = 1'b0;
        c = 0;
        wait_stim(1'b0, c, ok);
        chk("t4_stim_seen", ok, 1);
        d = c / 10;
        chk("t4_delay_model", delay_matches(0, d), 1);
        chk("t4_delay_range", (d >= 2000 && d <= 3023), 1);

        // Abort mid-STIM
        cyc(20);
        a.select = 1'b0;
        cyc(1);
        chk("t6_abort_stim", a.stim_led, 0);
        chk("t6_abort_busy", a.busy, 0);
        chk("t6_abort_best", a.best_ms, 20);
        chk("t6_abort_flags", {a.result_valid, a.false_start, a.timeout}, 0);

        // Reset mid-WAIT_DELAY
        a.mode = 2;
        a.select = 1'b1;
        cyc(40);
        chk("t6_wait_busy", a.busy, 1);
        chk("t6_wait_no_stim", a.stim_led, 0);
        rst = 1'b1;
        a.select = 1'b0;
        cyc(1);
        chk("t6_rst_busy", a.busy, 0);
        chk("t6_rst_stim", a.stim_led, 0);
        chk("t6_rst_best", a.best_ms, 9999);
        chk("t6_rst_result", a.result_ms, 0);
        rst = 1'b0;
        cyc(2);

        // Timeout at MAX_MS=50 on the second instance
        b.mode = 2;
        b.select = 1'b1;
        c = 0;
        wait_stim(1'b1, c, ok);
        chk("t3_stim_seen", ok, 1);
        cyc(499);
        chk("t3_before_timeout", b.timeout, 0);
        chk("t3_before_stim", b.stim_led, 1);
        cyc(1);
        chk("t3_timeout", b.timeout, 1);
        chk("t3_result", b.result_ms, 50);
        chk("t3_valid", b.result_valid, 0);
        chk("t3_stim_off", b.stim_led, 0);
        cyc(3);
        chk("t3_best_kept", b.best_ms, 50);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
